// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings, multiplier state type and opcode decode helper
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_LDI = 4'b1001;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    function automatic logic op_defined(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL,
            OP_SUB, OP_SLT, OP_MUL, OP_LDI, OP_NOR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_alu_pipe_if
// Description : Instruction handshake, result and debug-read bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [AW-1:0]    in_ra;
    logic [AW-1:0]    in_rb;
    logic [AW-1:0]    in_wa;
    logic             in_wen;
    logic [WIDTH-1:0] in_imm;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_err;
    logic [AW-1:0]    dbg_ra;
    logic [WIDTH-1:0] dbg_rd;

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_wa, in_wen, in_imm, dbg_ra,
        input  in_ready, out_valid, out_result, out_zero, out_err, dbg_rd
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_wa, in_wen, in_imm, dbg_ra,
        output in_ready, out_valid, out_result, out_zero, out_err, dbg_rd
    );
endinterface
`default_nettype wire

// File: rtl/iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : iter_multiplier
// Description : Shift-add multiplier, one partial product per cycle, low WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module iter_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      product
);
    localparam int CW = $clog2(WIDTH);

    mul_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy       = (r_state == MUL_BUSY);
    // done marks the edge performing the final step; product is that step's sum
    assign done       = busy && (r_cnt == CW'(WIDTH - 1));
    assign product    = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (done) begin
                        r_state <= MUL_IDLE;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : regfile_alu_pipe
// Description : Register file + ALU execute unit with EX/WB stages, forwarding
//               and an iterative multiplier that back-pressures the input
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    regfile_alu_pipe_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_regs [NREGS];

    logic             r_ex_valid;
    logic [WIDTH-1:0] r_ex_result;
    logic [AW-1:0]    r_ex_wa;
    logic             r_ex_wen;
    logic             r_ex_err;
    logic             r_ex_zero;
    logic [AW-1:0]    r_mul_wa;
    logic             r_mul_wen;

    logic             w_accept;
    logic             w_fwd_ok;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_alu;
    logic             w_err;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_result;

    assign bus.in_ready = !w_mul_busy;
    assign w_accept     = bus.in_valid && !w_mul_busy;
    assign w_mul_start  = w_accept && (bus.in_op == OP_MUL);

    // EX result bypasses the register file; R0 is never a forwarding target
    assign w_fwd_ok = r_ex_valid && r_ex_wen && !r_ex_err;
    assign w_opa = (w_fwd_ok && (r_ex_wa == bus.in_ra) && (bus.in_ra != '0))
                   ? r_ex_result : r_regs[bus.in_ra];
    assign w_opb = (w_fwd_ok && (r_ex_wa == bus.in_rb) && (bus.in_rb != '0))
                   ? r_ex_result : r_regs[bus.in_rb];

    always_comb begin
        w_alu = '0;
        w_err = !op_defined(bus.in_op);
        case (bus.in_op)
            OP_AND:  w_alu = w_opa & w_opb;
            OP_OR:   w_alu = w_opa | w_opb;
            OP_ADD:  w_alu = w_opa + w_opb;
            OP_SLL:  w_alu = w_opa << w_opb[SW-1:0];
            OP_SRL:  w_alu = w_opa >> w_opb[SW-1:0];
            OP_SUB:  w_alu = w_opa - w_opb;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
            OP_LDI:  w_alu = bus.in_imm;
            OP_NOR:  w_alu = ~(w_opa | w_opb);
            default: w_alu = '0;
        endcase
    end

    iter_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (w_opa),
        .b       (w_opb),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_wa  <= '0;
            r_mul_wen <= 1'b0;
        end else if (w_mul_start) begin
            r_mul_wa  <= bus.in_wa;
            r_mul_wen <= bus.in_wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_result <= '0;
            r_ex_wa     <= '0;
            r_ex_wen    <= 1'b0;
            r_ex_err    <= 1'b0;
            r_ex_zero   <= 1'b0;
        end else if (w_mul_done) begin
            r_ex_valid  <= 1'b1;
            r_ex_result <= w_mul_result;
            r_ex_wa     <= r_mul_wa;
            r_ex_wen    <= r_mul_wen;
            r_ex_err    <= 1'b0;
            r_ex_zero   <= (w_mul_result == '0);
        end else if (w_accept && (bus.in_op != OP_MUL)) begin
            r_ex_valid  <= 1'b1;
            r_ex_result <= w_alu;
            r_ex_wa     <= bus.in_wa;
            r_ex_wen    <= bus.in_wen;
            r_ex_err    <= w_err;
            r_ex_zero   <= (w_alu == '0);
        end else begin
            r_ex_valid  <= 1'b0;
        end
    end

    // Write-back: a valid EX entry commits at the following edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_ex_valid && r_ex_wen && !r_ex_err && (r_ex_wa != '0)) begin
            r_regs[r_ex_wa] <= r_ex_result;
        end
    end

    assign bus.out_valid  = r_ex_valid;
    assign bus.out_result = r_ex_result;
    assign bus.out_zero   = r_ex_zero;
    assign bus.out_err    = r_ex_err;
    assign bus.dbg_rd     = r_regs[bus.dbg_ra];

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_alu_pipe
// Description : Directed self-checking bench with an expected-result queue
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_alu_pipe;
    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                           C_SLL = 4'b0011, C_SRL = 4'b0100, C_SUB = 4'b0110,
                           C_SLT = 4'b0111, C_MUL = 4'b1000, C_LDI = 4'b1001,
                           C_NOR = 4'b1100, C_BAD = 4'b1111;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   waited;

    regfile_alu_pipe_if #(.WIDTH(32), .NREGS(32)) bus();

    regfile_alu_pipe #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            exp_t e;
            chk("out_valid_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_err",    32'(bus.out_err),  32'(e.err));
                chk("out_zero",   32'(bus.out_zero), 32'(e.res == 32'd0));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] wa, input logic [31:0] imm, input logic exp_out,
                         input logic [31:0] exp_res, input logic exp_err, output int nwait);
        logic rdy;
        logic accepted;
        bus.in_op    = op;
        bus.in_ra    = ra;
        bus.in_rb    = rb;
        bus.in_wa    = wa;
        bus.in_wen   = 1'b1;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        if (exp_out) sb.push_back('{exp_res, exp_err});
        nwait    = 0;
        accepted = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
            nwait++;
        end
        chk("accept_within_bound", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.dbg_ra = addr;
        #1;
        chk(tag, bus.dbg_rd, exp);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = '0; bus.in_ra = '0; bus.in_rb = '0; bus.in_wa = '0;
        bus.in_wen = 1'b0; bus.in_imm = '0; bus.dbg_ra = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",   32'(bus.in_ready),  32'd1);
        chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result,     32'd0);
        chk("rst_out_zero",   32'(bus.out_zero),  32'd0);
        chk("rst_out_err",    32'(bus.out_err),   32'd0);
        for (int a = 0; a < 32; a++) dbg("rst_dbg_rd", 5'(a), 32'd0);

        // forwarding chain, zero bubbles
        issue(C_LDI, 0, 0, 1, 32'd8, 1, 32'd8, 0, w);
        issue(C_LDI, 0, 0, 2, 32'd7, 1, 32'd7, 0, w);
        issue(C_ADD, 1, 2, 3, 32'd0, 1, 32'd15, 0, w);
        bus.in_valid = 1'b0;
        dbg("r3_before_wb", 5'd3, 32'd0);
        idle(1);
        dbg("r3_after_wb", 5'd3, 32'd15);
        dbg("r1_value",    5'd1, 32'd8);

        issue(C_SUB, 1, 1, 4, 32'd0, 1, 32'd0, 0, w);
        issue(C_LDI, 0, 0, 5, 32'd7, 1, 32'd7, 0, w);
        issue(C_LDI, 0, 0, 6, 32'd8, 1, 32'd8, 0, w);
        issue(C_SLT, 5, 6, 7, 32'd0, 1, 32'd1, 0, w);
        issue(C_LDI, 0, 0, 8, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, w);
        issue(C_LDI, 0, 0, 9, 32'd1, 1, 32'd1, 0, w);
        issue(C_SLT, 8, 9, 10, 32'd0, 1, 32'd1, 0, w);
        issue(C_SLT, 9, 8, 10, 32'd0, 1, 32'd0, 0, w);
        issue(C_LDI, 0, 0, 11, 32'd3, 1, 32'd3, 0, w);
        issue(C_LDI, 0, 0, 12, 32'd4, 1, 32'd4, 0, w);
        issue(C_NOR, 11, 12, 13, 32'd0, 1, 32'hFFFF_FFF8, 0, w);
        issue(C_OR,  11, 12, 13, 32'd0, 1, 32'd7, 0, w);
        issue(C_AND, 11, 12, 13, 32'd0, 1, 32'd0, 0, w);
        issue(C_SLL, 12, 11, 13, 32'd0, 1, 32'd32, 0, w);
        issue(C_LDI, 0, 0, 14, 32'h8000_0000, 1, 32'h8000_0000, 0, w);
        issue(C_LDI, 0, 0, 15, 32'd31, 1, 32'd31, 0, w);
        issue(C_SRL, 14, 15, 16, 32'd0, 1, 32'd1, 0, w);
        idle(2);
        dbg("r13_last_write", 5'd13, 32'd32);

        // multiply with the next instruction held behind it
        issue(C_LDI, 0, 0, 17, 32'h1234, 1, 32'h1234, 0, w);
        issue(C_LDI, 0, 0, 18, 32'h10, 1, 32'h10, 0, w);
        issue(C_MUL, 17, 18, 19, 32'd0, 1, 32'h0001_2340, 0, w);
        chk("mul_accept_no_wait", 32'(w), 32'd0);
        issue(C_ADD, 19, 17, 20, 32'd0, 1, 32'h0001_3574, 0, waited);
        chk("mul_ready_low_cycles", 32'(waited), 32'd32);
        idle(2);
        dbg("r19_product", 5'd19, 32'h0001_2340);
        dbg("r20_sum",     5'd20, 32'h0001_3574);

        // R0 stays zero and is never forwarded
        issue(C_LDI, 0, 0, 0, 32'd5, 1, 32'd5, 0, w);
        issue(C_ADD, 0, 0, 21, 32'd0, 1, 32'd0, 0, w);
        idle(2);
        dbg("r0_zero",  5'd0,  32'd0);
        dbg("r21_zero", 5'd21, 32'd0);

        // undefined opcode
        issue(C_LDI, 0, 0, 22, 32'h55, 1, 32'h55, 0, w);
        issue(C_BAD, 0, 0, 22, 32'hABCD, 1, 32'd0, 1, w);
        idle(2);
        dbg("r22_unchanged", 5'd22, 32'h55);

        // reset mid-multiply aborts without a result
        issue(C_MUL, 17, 18, 24, 32'd0, 0, 32'd0, 0, w);
        idle(10);
        chk("mul_busy_before_abort", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        idle(40);
        dbg("abort_r24", 5'd24, 32'd0);
        issue(C_LDI, 0, 0, 1, 32'd3, 1, 32'd3, 0, w);
        idle(2);
        dbg("post_abort_r1", 5'd1, 32'd3);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_alu_pipe.md
# regfile_alu_pipe

Parametrised two-stage execute unit: a NREGS x WIDTH register file (R0 hardwired to zero) feeding an ALU, with an EX stage and a registered write-back (WB) stage. It adds three things to the lab ALU/register-file pair: result forwarding, a valid/ready instruction handshake, and an iterative multi-cycle multiply that stalls the input. It sits between instruction decode and the rest of the lab CPU datapath.

## Interface
- WIDTH, 32, datapath width (≥ 8, power of two)
- NREGS, 32, register count (power of two, ≥ 2)
- AW, $clog2(NREGS), derived register-address width (localparam)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; one clock; all state cleared while low
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept; equals !mul_busy
- in_op  in  4  operation code
- in_ra, in_rb  in  AW  source register addresses
- in_wa  in  AW  destination register address
- in_wen  in  1  write destination
- in_imm  in  WIDTH  immediate, used by LDI only
- out_valid  out  1  EX result valid this cycle
- out_result  out  WIDTH  EX result
- out_zero  out  1  out_result == 0
- out_err  out  1  undefined opcode
- dbg_ra  in  AW  debug read address
- dbg_rd  out  WIDTH  combinational register-file contents at dbg_ra, without forwarding

## Operation
- Opcodes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, MUL 1000, LDI 1001, NOR 1100. All other codes are undefined.
- Acceptance happens on a clock edge where in_valid && in_ready && reset is high.
- Operand read: A = R[in_ra], B = R[in_rb]. Forwarding: if the EX register holds a valid, writing, non-error result whose wa equals the read address and that address is non-zero, the operand takes ex_result instead.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH.
  - SLT is signed two's complement; result is 1 or 0.
  - SLL and SRL are logical shifts by B[$clog2(WIDTH)-1:0].
  - MUL gives the low WIDTH bits of the product.
  - LDI gives in_imm.
- Single-cycle ops: the result is loaded into the EX register (ex_result, ex_wa, ex_wen, ex_err) at the accept edge.
- MUL FSM, states IDLE → BUSY → IDLE:
  - Operands are latched (forwarded) at accept.
  - One shift-add step per cycle for WIDTH cycles.
  - On the last step the product loads into the EX register.
  - in_ready is low throughout BUSY.
- Write-back: at the edge after a result enters EX, R[ex_wa] ← ex_result if ex_wen && !ex_err && ex_wa != 0. Writes to R0 are discarded.
- Undefined op: out_result = 0, out_err = 1, out_valid = 1, no register write.
- Reset values:
  - all registers 0
  - out_valid 0, out_result 0, out_zero 0, out_err 0
  - FSM IDLE, so in_ready = 1

## Timing
- Single-cycle op accepted at edge N:
  - out_valid high for the cycle N→N+1.
  - Register write at edge N+1.
  - dbg_rd shows the new value after edge N+1.
- A dependent instruction accepted at edge N+1 gets the result via forwarding: zero bubbles.
- MUL accepted at edge N:
  - in_ready low from N to N+WIDTH.
  - out_valid for cycle N+WIDTH→N+WIDTH+1.
  - in_ready high again after edge N+WIDTH.
- While BUSY, in_valid is ignored. The producer must hold the instruction until in_ready is high.
- out_valid is high for one cycle per accepted instruction. With no acceptance it falls to 0; out_result holds its value.
- Reset asserted mid-MUL aborts the multiply: no result, no write, and the unit is IDLE on release.

## Structure
- Package alu_pkg holds the opcode localparams (OP_AND … OP_NOR) and a helper returning whether an opcode is defined.
- Sub-module iter_multiplier (parameter WIDTH): start/busy/done handshake, shift-add datapath.
- The register file stays inline in the top module as a register array.

## Test plan
- Reset: hold reset low 4 cycles, release → in_ready = 1, out_valid = 0, dbg_rd = 0 for every address.
- Forwarding: back-to-back LDI r1 = 8, LDI r2 = 7, ADD r3 = r1 + r2 → out_result 15 on the third out_valid; dbg_rd(r3) = 15 one edge later.
- ALU results:
  - SUB r1 − r1 → 0 with out_zero = 1.
  - SLT 7, 8 → 1.
  - SLT 0xFFFFFFFF, 1 → 1.
  - NOR 3, 4 → 0xFFFFFFF8.
  - SRL 0x80000000 by 31 → 1.
- Multiply: MUL 0x1234 × 0x10 with in_valid held high behind it → in_ready low for exactly 32 cycles, out_result 0x12340, and the next instruction is accepted on the first cycle in_ready is high.
- R0 handling: LDI r0 = 5 → out_result 5, dbg_rd(r0) stays 0, and a following ADD r0 + r0 returns 0 (no forwarding from R0).
- Undefined op and reset abort:
  - op 1111 → out_err = 1, out_result = 0, destination unchanged.
  - Reset asserted mid-MUL → no write, in_ready = 1 after release.
